// File: rtl/armleocpu_mul_controller_pkg.sv
// armleocpu_mul_controller_pkg: shared multiply-group funct3 encodings, controller state encodings and helpers
//   XLEN      : datapath width (32)
//   mul_op_t  : funct3[1:0] encodings for MUL/MULH/MULHSU/MULHU
//   state_t   : 2-bit controller state encoding
//   neg       : two's-complement negation of an XLEN-bit value
package armleocpu_mul_controller_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {
        MUL_OP    = 2'd0,
        MULH_OP   = 2'd1,
        MULHSU_OP = 2'd2,
        MULHU_OP  = 2'd3
    } mul_op_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return ~x + 1'b1;
    endfunction
endpackage

// File: rtl/armleocpu_mul_controller_if.sv
// armleocpu_mul_controller_if: execute-to-multiply-controller request/response bundle
//   master (execute)    : drives valid, kill, funct3, rs1, rs2; sees ready, result, busy
//   slave  (controller) : the reverse
interface armleocpu_mul_controller_if;
    import armleocpu_mul_controller_pkg::*;
    logic            valid;
    logic            kill;
    logic [1:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            ready;
    logic [XLEN-1:0] result;
    logic            busy;
    modport master (output valid, kill, funct3, rs1, rs2, input ready, result, busy);
    modport slave  (input valid, kill, funct3, rs1, rs2, output ready, result, busy);
endinterface

// File: rtl/armleocpu_mul_controller_multiplier.sv
// armleocpu_multiplier: registered unsigned 32x32->64 multiplier, product one cycle after valid_i
//   clk, rst_n  : clock, async active-low reset
//   valid_i     : start; factors sampled on this cycle
//   factor0_i/1 : unsigned factors
//   ready_o     : product valid (one cycle after valid_i)
//   result_o    : 64-bit product
module armleocpu_multiplier
    import armleocpu_mul_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   factor0_i,
    input  logic [XLEN-1:0]   factor1_i,
    output logic              ready_o,
    output logic [2*XLEN-1:0] result_o
);
    logic              ready_q;
    logic [2*XLEN-1:0] result_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= valid_i;
            if (valid_i)
                result_q <= 64'(factor0_i) * 64'(factor1_i);
        end
    end
    assign ready_o  = ready_q;
    assign result_o = result_q;
endmodule

// File: rtl/armleocpu_mul_controller.sv
// armleocpu_mul_controller: RV32M MUL/MULH/MULHSU/MULHU sequencer around an unsigned 1-cycle multiplier
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of the execute request bundle (valid/kill/funct3/rs1/rs2 in,
//                ready pulse / held result / busy out)
module armleocpu_mul_controller
    import armleocpu_mul_controller_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    armleocpu_mul_controller_if.slave     bus
);
    state_t            state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic              negate_q, negate_d, high_q, high_d, ready_q, ready_d;
    logic              mul_ready;
    logic [2*XLEN-1:0] prod, p;
    mul_op_t           op;
    logic              sa, sb;

    armleocpu_multiplier u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (state_q == MULT),
        .factor0_i (a_q),
        .factor1_i (b_q),
        .ready_o   (mul_ready),
        .result_o  (prod)
    );

    // Operands are turned into magnitudes up front so the multiplier only sees unsigned values;
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign op = mul_op_t'(bus.funct3);
    assign sa = (op == MULH_OP || op == MULHSU_OP) && bus.rs1[XLEN-1];
    assign sb = (op == MULH_OP) && bus.rs2[XLEN-1];
    assign p  = negate_q ? ~prod + 64'd1 : prod;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        negate_d = negate_q;
        high_d   = high_q;
        result_d = result_q;
        ready_d  = 1'b0;
        if (bus.kill)
            state_d = IDLE;
        else
            case (state_q)
                IDLE: if (bus.valid) begin
                    a_d      = sa ? neg(bus.rs1) : bus.rs1;
                    b_d      = sb ? neg(bus.rs2) : bus.rs2;
                    negate_d = (op == MULH_OP) ? bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1] :
                               (op == MULHSU_OP) ? bus.rs1[XLEN-1] : 1'b0;
                    high_d   = op != MUL_OP;
                    state_d  = MULT;
                end
                MULT: state_d = FIX;
                FIX: if (mul_ready) begin
                    result_d = high_q ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            negate_q <= 1'b0;
            high_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            negate_q <= negate_d;
            high_q   <= high_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.result = result_q;
    assign bus.busy   = state_q != IDLE;
endmodule

// File: tb/tb_armleocpu_mul_controller.sv
// tb_armleocpu_mul_controller: directed checks of latency, sign handling, back-to-back, kill and async reset
module tb_armleocpu_mul_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    armleocpu_mul_controller_if bus();
    armleocpu_mul_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp);
        bus.funct3 = f;
        bus.rs1    = x;
        bus.rs2    = y;
        bus.valid  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            chk({tag, "_ready"}, 64'(bus.ready), (c == 3) ? 64'd1 : 64'd0);
        end
        chk({tag, "_result"}, 64'(bus.result), 64'(exp));
        bus.valid = 1'b0;
        cyc();
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_idle_ready"}, 64'(bus.ready), 64'd0);
        chk({tag, "_held"}, 64'(bus.result), 64'(exp));
    endtask

    initial begin
        bus.valid  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 2'd0;
        bus.rs1    = '0;
        bus.rs2    = '0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        rst_n = 1'b1;
        cyc();

        run_op("mul", 2'd0, 32'h12345678, 32'h00000010, 32'h23456780);
        run_op("mulh_minmin", 2'd1, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulh_neg1", 2'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF);
        run_op("mulhsu", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulhu", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);

        // back-to-back: valid stays high, operands change once the first ready is seen
        bus.funct3 = 2'd0;
        bus.rs1    = 32'd3;
        bus.rs2    = 32'd5;
        bus.valid  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            chk($sformatf("b2b_ready_c%0d", c), 64'(bus.ready), (c == 3 || c == 7) ? 64'd1 : 64'd0);
            chk($sformatf("b2b_busy_c%0d", c), 64'(bus.busy), (c == 4 || c == 8) ? 64'd0 : 64'd1);
            if (c == 3) begin
                chk("b2b_first", 64'(bus.result), 64'd15);
                bus.funct3 = 2'd3;
                bus.rs1    = 32'h00010000;
                bus.rs2    = 32'h00030000;
            end
            if (c == 7) begin
                chk("b2b_second", 64'(bus.result), 64'd3);
                bus.valid = 1'b0;
            end
        end

        // kill during MULT
        bus.funct3 = 2'd0;
        bus.rs1    = 32'd7;
        bus.rs2    = 32'd9;
        bus.valid  = 1'b1;
        cyc();
        chk("kmult_busy_pre", 64'(bus.busy), 64'd1);
        bus.kill = 1'b1;
        cyc();
        chk("kmult_busy", 64'(bus.busy), 64'd0);
        chk("kmult_ready", 64'(bus.ready), 64'd0);
        chk("kmult_result", 64'(bus.result), 64'd3);
        bus.kill  = 1'b0;
        bus.valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("kmult_quiet_ready", 64'(bus.ready), 64'd0);
            chk("kmult_quiet_busy", 64'(bus.busy), 64'd0);
        end

        // kill during FIX
        bus.valid = 1'b1;
        cyc();
        cyc();
        chk("kfix_busy_pre", 64'(bus.busy), 64'd1);
        bus.kill = 1'b1;
        cyc();
        chk("kfix_busy", 64'(bus.busy), 64'd0);
        chk("kfix_ready", 64'(bus.ready), 64'd0);
        chk("kfix_result", 64'(bus.result), 64'd3);
        bus.kill  = 1'b0;
        bus.valid = 1'b0;
        cyc();
        chk("kfix_quiet_ready", 64'(bus.ready), 64'd0);

        run_op("after_kill", 2'd0, 32'd7, 32'd9, 32'd63);

        // asynchronous reset while in FIX
        bus.funct3 = 2'd0;
        bus.rs1    = 32'd2;
        bus.rs2    = 32'd3;
        bus.valid  = 1'b1;
        cyc();
        cyc();
        chk("arst_busy_pre", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_ready", 64'(bus.ready), 64'd0);
        chk("arst_result", 64'(bus.result), 64'd0);
        bus.valid = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("arst_after_ready", 64'(bus.ready), 64'd0);
            chk("arst_after_busy", 64'(bus.busy), 64'd0);
        end

        run_op("after_rst", 2'd3, 32'h00020000, 32'h00020000, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
